// File: rtl/conv_window_buffer.sv
// Streaming line buffer and sliding N x N window generator (stride 1, no padding).
// Emits one row-major packed window per accepted pixel once a full window lies inside the frame.
module conv_window_buffer #(
    parameter int unsigned N       = 3,
    parameter int unsigned BitSize = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned H       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BitSize-1:0]          in_pixel,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BitSize*N*N-1:0]      out_window,
    output logic                        frame_done
);

    localparam int unsigned NN   = N * N;
    localparam int unsigned WINW = BitSize * NN;
    localparam int unsigned CW   = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned RW   = (H > 1) ? $clog2(H) : 1;

    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [BitSize-1:0]  win_q      [N][N];
    logic [BitSize-1:0]  win_next_c [N][N];
    logic [BitSize-1:0]  lb_q       [N-1][W];
    logic                out_valid_q, out_valid_d;
    logic [WINW-1:0]     out_window_q, out_window_d;
    logic                frame_done_q, frame_done_d;

    logic                accept_c;
    logic                last_col_c;
    logic                last_row_c;
    logic                win_ok_c;
    logic [WINW-1:0]     win_flat_c;

    assign in_ready   = !(out_valid_q && !out_ready);
    assign accept_c   = in_valid && in_ready;
    assign last_col_c = (col_q == CW'(W - 1));
    assign last_row_c = (row_q == RW'(H - 1));
    assign win_ok_c   = (row_q >= RW'(N - 1)) && (col_q >= CW'(N - 1));

    // Window after this pixel: rows shift left, right column fed from line buffers and in_pixel.
    always_comb begin
        win_next_c = win_q;
        for (int r = 0; r < int'(N); r++) begin
            for (int c = 0; c < int'(N) - 1; c++) begin
                win_next_c[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < int'(N) - 1; r++) begin
            win_next_c[r][N-1] = lb_q[r][col_q];
        end
        win_next_c[N-1][N-1] = in_pixel;
    end

    always_comb begin
        win_flat_c = '0;
        for (int r = 0; r < int'(N); r++) begin
            for (int c = 0; c < int'(N); c++) begin
                win_flat_c[(int'(NN) - 1 - (r * int'(N) + c)) * int'(BitSize) +: BitSize] = win_next_c[r][c];
            end
        end
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        out_valid_d  = out_valid_q;
        out_window_d = out_window_q;
        frame_done_d = 1'b0;
        if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept_c) begin
            col_d = last_col_c ? '0 : col_q + CW'(1);
            if (last_col_c) begin
                row_d = last_row_c ? '0 : row_q + RW'(1);
            end
            if (win_ok_c) begin
                out_valid_d  = 1'b1;
                out_window_d = win_flat_c;
            end
            frame_done_d = last_col_c && last_row_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_window_q <= '0;
            frame_done_q <= 1'b0;
            for (int r = 0; r < int'(N); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_window_q <= out_window_d;
            frame_done_q <= frame_done_d;
            if (accept_c) begin
                win_q <= win_next_c;
            end
        end
    end

    // Line buffers cascade at col: oldest row in buffer 0, newest pixel enters the last buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < int'(N) - 1; k++) begin
                for (int a = 0; a < int'(W); a++) begin
                    lb_q[k][a] <= '0;
                end
            end
        end else if (accept_c) begin
            for (int k = 0; k < int'(N) - 2; k++) begin
                lb_q[k][col_q] <= lb_q[k+1][col_q];
            end
            lb_q[N-2][col_q] <= in_pixel;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_window = out_window_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/conv_window_buffer.md
Name: conv_window_buffer

Overview:
- Streaming line-buffer and sliding-window generator; sits directly upstream of dot_NxN.
- Accepts one BitSize-bit pixel per cycle in raster order and emits every fully-inside N×N window (stride 1, no padding).
- Window is packed in exactly the in_data layout dot_NxN consumes; one output per accepted pixel once the window is complete.

Parameters:
- N, 3, window edge length; matches dot_NxN N.
- BitSize, 4, pixel width in bits (signed data, handled as opaque bits here).
- W, 8, image width in pixels, W ≥ N.
- H, 8, image height in pixels, H ≥ N.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_pixel valid this cycle.
- in_ready  output  1  block can accept a pixel this cycle.
- in_pixel  input  BitSize  raster-order pixel.
- out_valid  output  1  out_window holds a valid window.
- out_ready  input  1  downstream accepts out_window.
- out_window  output  BitSize*N*N  window, row-major, top-left pixel in MSB slice, bottom-right (newest) in bits [BitSize-1:0]; row r col c at slice index (N*N-1)-(r*N+c).
- frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset (async assert, sync deassert): out_valid=0, frame_done=0, out_window=0, col=0, row=0, line buffers and window registers cleared. in_ready=1 during and after reset.
- Accept: a pixel is accepted when in_valid && in_ready.
- in_ready = !(out_valid && !out_ready); this is combinational. The block holds at most one pending window.
- Storage:
  - N-1 line buffers of W entries each, addressed by col.
  - An N×N shift register window.
  - On accept, each window row shifts left by one column. Column N-1 of row k loads line buffer k's entry at col (oldest row at top); the bottom row loads in_pixel.
  - Line buffers cascade at col: buffer k takes buffer k+1, and the last buffer takes in_pixel.
- Counters:
  - col increments per accept and wraps W-1→0.
  - On wrap, row increments; row wraps H-1→0 (next frame, no gap required).
- Output:
  - On the accept of pixel (row,col) with row ≥ N-1 and col ≥ N-1, out_window is registered with the updated window and out_valid=1 on the next cycle (latency 1).
  - Otherwise out_valid clears when out_ready is high.
  - out_valid and out_window hold stable while out_valid && !out_ready.
- Window count: exactly (W-N+1)*(H-N+1) windows per frame. Windows never span row wrap; the col ≥ N-1 gate guarantees this.
- frame_done: registered, asserted the cycle after accepting pixel (H-1,W-1), coincident with the last out_valid.
- Simultaneous events:
  - Accept while out_valid && out_ready: the old window is consumed and the new window loads the same edge, so output is back-to-back.
  - in_valid low: no state changes except clearing out_valid on handshake.
- Frame boundary: line buffer contents from the previous frame are don't-care because the row ≥ N-1 gate suppresses stale windows.
- Reset mid-frame: all counters return to 0 and any pending window is dropped. The next accepted pixel is (0,0) of a new frame.

Test Plan:
- Default fill, N=3, W=5, H=4, BitSize=4, pixel = (row*5+col) mod 16, in_valid=1, out_ready=1:
  - First out_valid occurs one cycle after pixel 12 is accepted.
  - out_window = {0,1,2,5,6,7,10,11,12}.
  - 6 windows total per frame.
- Same frame, final window: out_window = {7,8,9,12,13,14,1,2,3}, with frame_done=1 in the same cycle; frame_done=1 for exactly one cycle per frame.
- Backpressure:
  - Drop out_ready for 3 cycles while out_valid=1.
  - in_ready=0 for those cycles, out_window is stable, and no pixel is lost.
  - The subsequent window sequence is identical to the no-stall run.
- Input bubbles: in_valid toggled 1-0-1 across the frame → same 6 windows in the same order; out_valid only after accepts.
- Reset mid-frame:
  - Assert rst after 9 pixels; all outputs go 0 immediately.
  - Restart the frame; the first window again equals {0,1,2,5,6,7,10,11,12}.
- Back-to-back frames: two frames streamed with no gap → 12 windows, 2 frame_done pulses, and the second frame's first window equals the first frame's.
